// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: shares one four-digit seven-segment display between three requesters.
// Latency: grant, disp_val, disp_blank and busy are registered; each decision appears one clk after its inputs are sampled.
// Backpressure: none; a requester holds req high until it sees its grant bit.
//
// Arbitration: fixed priority (req[0] highest), a minimum-hold window before an owner
// may be preempted, and a fairness timeout. A blanked gap is inserted between owners
// so the digit multiplexer never shows one source's segments in another's slot.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   req[2:0]           request per source, bit 0 highest priority
//   val0..val2[15:0]   source digits {A,B,C,D}, A = bits 15:12 (leftmost)
//   blk0..blk2[3:0]    source per-digit blank, bit 3 = digit A
//   grant[2:0]         one-hot current owner, 0 when IDLE or GAP
//   disp_val[15:0]     digit values to the display mux
//   disp_blank[3:0]    per-digit blank to the display mux
//   busy               high while in OWN or GAP
//
// Build option: define ARB_PREEMPT_EN to let a higher-priority request take the display
// from an owner that has held it for MIN_HOLD ticks. Without it an owner leaves only by
// releasing its request or by the MAX_HOLD timeout.

module seg_display_arbiter #(
    parameter int TICK_DIV  = 100000,  // clk cycles per tick, >= 2
    parameter int MIN_HOLD  = 250,     // ticks before preemption is allowed
    parameter int MAX_HOLD  = 2000,    // ticks before eviction when others wait
    parameter int GAP_TICKS = 5        // blanked ticks between owners, >= 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [15:0] val0,
    input  logic [15:0] val1,
    input  logic [15:0] val2,
    input  logic [3:0]  blk0,
    input  logic [3:0]  blk1,
    input  logic [3:0]  blk2,
    output logic [2:0]  grant,
    output logic [15:0] disp_val,
    output logic [3:0]  disp_blank,
    output logic        busy
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);
`ifdef ARB_PREEMPT_EN
    // A MIN_HOLD above MAX_HOLD could never be reached by the saturating counter.
    localparam logic [HW-1:0] HOLD_MIN = HW'((MIN_HOLD > MAX_HOLD) ? MAX_HOLD : MIN_HOLD);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state;
    logic [1:0]    owner;        // index of the current (or last) owner
    logic [HW-1:0] hold_cnt;     // ticks spent by the current owner, saturating
    logic [GW-1:0] gap_cnt;      // ticks spent in the current gap
    logic          last_ev_vld;  // last owner was evicted by timeout
    logic [1:0]    last_ev;      // which source was evicted
    logic [PW-1:0] pre_cnt;
    logic          tick;

    // ------------------------------------------------------------------
    // Tick prescaler: free-running 0..TICK_DIV-1, tick on the wrap cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    assign tick = (pre_cnt == PRE_LAST);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    // Lowest set bit; callers only use the result when r is non-zero.
    function automatic logic [1:0] lowest(input logic [2:0] r);
        logic [1:0] idx;
        if (r[0]) begin
            idx = 2'd0;
        end else if (r[1]) begin
            idx = 2'd1;
        end else begin
            idx = 2'd2;
        end
        return idx;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // ------------------------------------------------------------------
    // Owner data select and exit conditions
    // ------------------------------------------------------------------
    logic [15:0]   own_val;
    logic [3:0]    own_blk;
    logic [2:0]    own_bit;
    logic          rule_rel;
    logic          rule_pre;
    logic          rule_tmo;
    logic [HW-1:0] hold_nxt;
    logic [2:0]    ev_mask;
    logic [2:0]    cand;
    logic [1:0]    pick;

    always_comb begin
        own_val = val0;
        own_blk = blk0;
        case (owner)
            2'd1: begin
                own_val = val1;
                own_blk = blk1;
            end
            2'd2: begin
                own_val = val2;
                own_blk = blk2;
            end
            default: begin
                own_val = val0;
                own_blk = blk0;
            end
        endcase
    end

    assign own_bit  = onehot(owner);
    assign rule_rel = ~|(req & own_bit);
    assign rule_tmo = (|(req & ~own_bit)) && (hold_cnt >= HOLD_MAX);

`ifdef ARB_PREEMPT_EN
    // Bits below the owner's bit are the higher-priority sources.
    logic [2:0] hi_mask;
    assign hi_mask  = 3'(own_bit - 3'd1);
    assign rule_pre = (|(req & hi_mask)) && (hold_cnt >= HOLD_MIN);
`else
    assign rule_pre = 1'b0;
`endif

    assign hold_nxt = (tick && (hold_cnt != HOLD_MAX)) ? hold_cnt + 1'b1 : hold_cnt;

    // Gap exit choice: skip the source just evicted by timeout so the waiting
    // source gets its turn, unless nobody else is asking.
    assign ev_mask = last_ev_vld ? onehot(last_ev) : 3'b000;
    assign cand    = req & ~ev_mask;
    assign pick    = (|cand) ? lowest(cand) : lowest(req);

    // ------------------------------------------------------------------
    // Arbitration FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= 2'd0;
            hold_cnt    <= '0;
            gap_cnt     <= '0;
            last_ev_vld <= 1'b0;
            last_ev     <= 2'd0;
            grant       <= 3'b000;
            disp_val    <= 16'h0000;
            disp_blank  <= 4'b1111;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= OWN;
                        owner    <= lowest(req);
                        grant    <= onehot(lowest(req));
                        hold_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end

                OWN: begin
                    // Mirror the owner's live data every cycle.
                    disp_val   <= own_val;
                    disp_blank <= own_blk;
                    hold_cnt   <= hold_nxt;
                    if (rule_rel || rule_pre || rule_tmo) begin
                        state       <= GAP;
                        grant       <= 3'b000;
                        disp_blank  <= 4'b1111;
                        gap_cnt     <= '0;
                        // Only a pure timeout is remembered for the fairness skip.
                        last_ev_vld <= !rule_rel && !rule_pre;
                        last_ev     <= owner;
                    end
                end

                GAP: begin
                    if (tick) begin
                        if (gap_cnt == GAP_LAST) begin
                            last_ev_vld <= 1'b0;
                            if (|req) begin
                                state    <= OWN;
                                owner    <= pick;
                                grant    <= onehot(pick);
                                hold_cnt <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state      <= IDLE;
                    grant      <= 3'b000;
                    disp_blank <= 4'b1111;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with TICK_DIV=4, MIN_HOLD=2, MAX_HOLD=8, GAP_TICKS=1.
// cyc counts clk edges since reset release; ticks land on edges where cyc is a multiple of 4.
// Expected edge numbers below are hand-derived from that tick phase.

module tb_seg_display_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [15:0] val0, val1, val2;
    logic [3:0]  blk0, blk1, blk2;
    logic [2:0]  grant;
    logic [15:0] disp_val;
    logic [3:0]  disp_blank;
    logic        busy;

    int cyc = 0;
    int n_pass = 0;
    int n_fail = 0;
    int n_chk = 0;

    seg_display_arbiter #(
        .TICK_DIV (4),
        .MIN_HOLD (2),
        .MAX_HOLD (8),
        .GAP_TICKS(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .val0      (val0),
        .val1      (val1),
        .val2      (val2),
        .blk0      (blk0),
        .blk1      (blk1),
        .blk2      (blk2),
        .grant     (grant),
        .disp_val  (disp_val),
        .disp_blank(disp_blank),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until grant equals exp; returns the edge number, or -1 if the budget expires.
    task automatic wait_grant(input logic [2:0] exp, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            step();
            if (grant === exp) begin
                at = cyc;
                break;
            end
        end
    endtask

    // Drop all requests, wait for IDLE, then align to just after a tick edge.
    task automatic go_idle();
        req = 3'b000;
        for (int i = 0; i < 64 && busy !== 1'b0; i++) step();
        chk("reach_idle", 32'(busy), 32'd0);
        for (int i = 0; i < 4 && (cyc % 4) != 0; i++) step();
    endtask

    initial begin
        int t;
        int at;

        reset = 1'b1;
        req   = 3'b000;
        val0  = 16'h0000; val1 = 16'h0000; val2 = 16'h0000;
        blk0  = 4'b0000;  blk1 = 4'b0000;  blk2 = 4'b0000;
        step(); step(); step();

        // 1. Reset values and idle behaviour
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_val",   32'(disp_val), 32'h0);
        chk("rst_blank", 32'(disp_blank), 32'hF);
        chk("rst_busy",  32'(busy), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle_grant", 32'(grant), 32'h0);
            chk("idle_blank", 32'(disp_blank), 32'hF);
            chk("idle_busy",  32'(busy), 32'h0);
        end

        // 2. Single grant, long hold by a lone requester, release through the gap
        go_idle();
        t = cyc;
        val2 = 16'h1234; blk2 = 4'b0000; req = 3'b100;
        step();
        chk("s2_grant",       32'(grant), 32'h4);
        chk("s2_busy",        32'(busy), 32'h1);
        chk("s2_blank_first", 32'(disp_blank), 32'hF);
        step();
        chk("s2_val",   32'(disp_val), 32'h1234);
        chk("s2_blank", 32'(disp_blank), 32'h0);
        for (int i = 0; i < 40; i++) begin
            step();
            chk("s2_hold_lone", 32'(grant), 32'h4);
        end
        req = 3'b000;
        step();
        chk("s2_gap_grant", 32'(grant), 32'h0);
        chk("s2_gap_blank", 32'(disp_blank), 32'hF);
        chk("s2_gap_val",   32'(disp_val), 32'h1234);
        chk("s2_gap_busy",  32'(busy), 32'h1);
        at = -1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (busy === 1'b0) begin
                at = cyc;
                break;
            end
        end
        chk("s2_idle_at", 32'(at), 32'(t + 44));

        // 3. Higher-priority request arrives while source 2 owns
        go_idle();
        t = cyc;
        req = 3'b100;
        step();
        chk("s3_grant2", 32'(grant), 32'h4);
        req = 3'b101;
        wait_grant(3'b000, 40, at);
`ifdef ARB_PREEMPT_EN
        chk("s3_gap_at", 32'(at), 32'(t + 9));
        wait_grant(3'b001, 8, at);
        chk("s3_grant0_at", 32'(at), 32'(t + 12));
`else
        chk("s3_gap_at", 32'(at), 32'(t + 33));
        wait_grant(3'b001, 8, at);
        chk("s3_grant0_at", 32'(at), 32'(t + 36));
`endif

        // 4. Fairness with two constant requesters
        go_idle();
        t = cyc;
        req = 3'b011;
        step();
        chk("s4_grant0", 32'(grant), 32'h1);
        wait_grant(3'b000, 40, at);
        chk("s4_gap1_at", 32'(at), 32'(t + 33));
        wait_grant(3'b010, 8, at);
        chk("s4_grant1_at", 32'(at), 32'(t + 36));
        wait_grant(3'b000, 40, at);
`ifdef ARB_PREEMPT_EN
        chk("s4_gap2_at", 32'(at), 32'(t + 45));
        wait_grant(3'b001, 8, at);
        chk("s4_regrant0_at", 32'(at), 32'(t + 48));
        wait_grant(3'b010, 48, at);
        chk("s4_regrant1_at", 32'(at), 32'(t + 84));
`else
        chk("s4_gap2_at", 32'(at), 32'(t + 69));
        wait_grant(3'b001, 8, at);
        chk("s4_regrant0_at", 32'(at), 32'(t + 72));
        wait_grant(3'b010, 48, at);
        chk("s4_regrant1_at", 32'(at), 32'(t + 108));
`endif

        // 5. Release and higher-priority request on the same clk
        go_idle();
        t = cyc;
        val0 = 16'h0000; blk0 = 4'b0000;
        val1 = 16'h5A5A; blk1 = 4'b0011;
        req = 3'b010;
        step();
        chk("s5_grant1", 32'(grant), 32'h2);
        step();
        chk("s5_val1",   32'(disp_val), 32'h5A5A);
        chk("s5_blank1", 32'(disp_blank), 32'h3);
        req = 3'b001;
        step();
        chk("s5_gap_grant", 32'(grant), 32'h0);
        chk("s5_gap_blank", 32'(disp_blank), 32'hF);
        chk("s5_gap_val",   32'(disp_val), 32'h5A5A);
        step();
        chk("s5_grant0", 32'(grant), 32'h1);
        chk("s5_edge",   32'(cyc), 32'(t + 4));

        // 6. Live update of the owner's digits and blanks
        step();
        chk("s6_val_before",   32'(disp_val), 32'h0000);
        chk("s6_blank_before", 32'(disp_blank), 32'h0);
        val0 = 16'hABCD; blk0 = 4'b1000;
        chk("s6_val_registered", 32'(disp_val), 32'h0000);
        step();
        chk("s6_val_after",   32'(disp_val), 32'hABCD);
        chk("s6_blank_after", 32'(disp_blank), 32'h8);
        chk("s6_grant_kept",  32'(grant), 32'h1);

        // Reset while owning: straight back to reset values, no gap
        reset = 1'b1;
        step();
        chk("rst_own_grant", 32'(grant), 32'h0);
        chk("rst_own_blank", 32'(disp_blank), 32'hF);
        chk("rst_own_val",   32'(disp_val), 32'h0);
        chk("rst_own_busy",  32'(busy), 32'h0);
        reset = 1'b0;
        req = 3'b000;
        step();
        chk("post_rst_busy", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
Shares the four-digit seven-segment display between three independent requesters (e.g. score, status and debug sources). Fixed priority with a minimum-hold window and a fairness timeout. Inserts a blanked gap between owners to prevent ghosting. Outputs feed the digit multiplexer's A/B/C/D value inputs and its blank[3:0] input directly.

Parameters:
TICK_DIV, 100000, clk cycles per timing tick (1 ms at 100 MHz); legal range ≥2
MIN_HOLD, 250, ticks an owner keeps the display before preemption is allowed
MAX_HOLD, 2000, ticks after which an owner is evicted if any other requester waits
GAP_TICKS, 5, ticks of forced all-blank between owners; legal range ≥1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req  in  3  request per source; bit 0 highest priority
val0  in  16  source 0 digits {A,B,C,D}; A = bits 15:12 = leftmost
val1  in  16  source 1 digits
val2  in  16  source 2 digits
blk0  in  4  source 0 per-digit blank; bit 3 = A
blk1  in  4  source 1 blank
blk2  in  4  source 2 blank
grant  out  3  one-hot current owner, or 0
disp_val  out  16  digits to the display mux
disp_blank  out  4  blank to the display mux
busy  out  1  high in OWN or GAP

Behaviour:
- Reset values: grant=0, disp_val=0, disp_blank=4'b1111, busy=0, state=IDLE. All counters are cleared. Reset asserted mid-operation returns to these values on the next edge; no gap is inserted.
- Prescaler: counts 0..TICK_DIV-1. tick is a one-clk pulse when the count wraps. The count restarts from 0 out of reset.
- Outputs are registered. Each decision takes effect one clk after the edge at which its inputs are sampled.
- IDLE:
  - If req≠0, go to OWN with owner = lowest set bit of req. Clear hold_cnt.
  - Otherwise stay in IDLE.
- OWN:
  - grant = onehot(owner). disp_val and disp_blank follow the owner's val/blk with one-cycle latency, including changes made during ownership. busy=1.
  - hold_cnt increments on tick and saturates at MAX_HOLD.
  - Exit to GAP, highest rule first:
    (a) req[owner]=0 → release.
    (b) A higher-priority req bit is set and hold_cnt≥MIN_HOLD → preempt.
    (c) Any other req bit is set and hold_cnt≥MAX_HOLD → timeout; record last_evicted=owner.
  - Rules (a) and (b) clear last_evicted.
- GAP:
  - grant=0, disp_blank=4'b1111, disp_val holds its last value. busy=1.
  - gap_cnt increments on tick. After GAP_TICKS ticks, choose the new owner:
    - the lowest set bit of req excluding last_evicted;
    - if that set is empty, the lowest set bit of req;
    - if req=0, go to IDLE.
  - Clear last_evicted whenever a new owner is chosen.
  - A request that rises during GAP is eligible at the GAP exit.
- Simultaneous events:
  - Release together with a higher-priority request: rule (a) applies, and the gap is still inserted.
  - A tick on the same clk as a req change: the counter update and the exit decision use the same sampled values.
- A single requester holding req high stays owner indefinitely, since rule (c) needs a competitor.

Optional Feature:
Macro ARB_PREEMPT_EN.
- Defined: rule (b) is active as described.
- Not defined: rule (b) is compiled out. An owner loses the display only by release (a) or timeout (c), regardless of priority.

Test Plan:
Sim settings for all scenarios: TICK_DIV=4, MIN_HOLD=2, MAX_HOLD=8, GAP_TICKS=1; tick every 4 clk.
1. Reset then idle: req=0 for 50 clk → grant=0, disp_blank=1111, busy=0 throughout. Assert reset during OWN → grant=0 and disp_blank=1111 on the next clk.
2. Single grant: req=3'b100, val2=16'h1234, blk2=0 → grant=3'b100 one clk later. The following clk gives disp_val=1234, disp_blank=0000. Drop req → GAP (disp_blank=1111, grant=0) for one tick, then IDLE.
3. Preemption (ARB_PREEMPT_EN defined): source 2 owns, then req[0] rises at hold_cnt=0 → no change until hold_cnt=2. Then 1 tick of GAP, then grant=3'b001. Repeat with the macro undefined → source 2 keeps the display until hold_cnt=8, then source 0 takes over.
4. Fairness: req=3'b011 held constantly → source 0 owns 8 ticks, GAP, then source 1 owns 8 ticks, GAP, then source 0. Ownership alternates; source 1 is never starved.
5. Simultaneous release and request: source 1 owns; req goes 3'b010→3'b001 on one clk → GAP of 1 tick, then grant=3'b001.
6. Live update: source 0 owns; change val0 from 16'h0000 to 16'hABCD → disp_val=ABCD exactly 1 clk later, and grant is unchanged.
